// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//    Inter-stage pipeline register with a valid/ready handshake on both sides.
//    With SKID = 1 it holds up to two beats (head + skid) so that in_ready
//    comes straight from a flop and does not depend on out_ready. With
//    SKID = 0 it is a single register with a combinational in_ready.
//    Control is forced to zero whenever the output is not valid, so an empty
//    stage presents a NOP downstream. A saturating counter records stall cycles.
//
// Parameters
//    DATA_W  payload width (never zeroed except at reset)
//    CTRL_W  control width (zeroed on bubble)
//    SKID    1 = two-entry skid buffer, 0 = single register
//    CNT_W   stall counter width
//
// Ports
//    clk, rst              clock, asynchronous active-high reset
//    in_valid/in_ready     upstream handshake
//    in_data/in_ctrl       upstream payload and control
//    flush                 squash held beats and any beat offered this cycle
//    out_valid/out_ready   downstream handshake
//    out_data/out_ctrl     head payload and control (ctrl = 0 when not valid)
//    occupancy             number of beats held (0..2)
//    stall_cnt             saturating count of out_valid & !out_ready cycles
module pipe_stage_skid #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 9,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // State value equals the number of beats held.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_in_ready;
   logic [DATA_W-1:0]   r_head_data;
   logic [CTRL_W-1:0]   r_head_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_out_valid;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_stall;

   assign w_out_valid = (r_state != S_EMPTY);

   // Skid variant: in_ready is a flop, cut from out_ready.
   // Single-register variant: accept when empty or when the head leaves now.
   assign in_ready   = (SKID != 0) ? r_in_ready : (!w_out_valid | out_ready);

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = w_out_valid & out_ready;
   assign w_stall    = w_out_valid & ~out_ready;

   assign out_valid  = w_out_valid;
   assign out_data   = r_head_data;
   assign out_ctrl   = w_out_valid ? r_head_ctrl : '0;
   assign occupancy  = r_state;
   assign stall_cnt  = r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_head_data <= '0;
         r_head_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
         r_stall_cnt <= '0;
      end else begin
         // Flush does not touch the stall counter.
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;

         if (flush) begin
            // Data registers keep stale contents; only validity is dropped.
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
         end else begin
            case (r_state)
               S_EMPTY: begin
                  if (w_in_fire) begin
                     r_head_data <= in_data;
                     r_head_ctrl <= in_ctrl;
                     r_state     <= S_ONE;
                  end
               end
               S_ONE: begin
                  if (w_in_fire && w_out_fire) begin
                     r_head_data <= in_data;
                     r_head_ctrl <= in_ctrl;
                  end else if (w_in_fire) begin
                     // Only reachable with SKID = 1: in the single-register
                     // variant an accept while full implies the head leaves.
                     r_skid_data <= in_data;
                     r_skid_ctrl <= in_ctrl;
                     r_state     <= S_TWO;
                     r_in_ready  <= 1'b0;
                  end else if (w_out_fire) begin
                     r_state <= S_EMPTY;
                  end
               end
               S_TWO: begin
                  if (w_out_fire) begin
                     r_head_data <= r_skid_data;
                     r_head_ctrl <= r_skid_ctrl;
                     r_state     <= S_ONE;
                     r_in_ready  <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= S_EMPTY;
                  r_in_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. Three instances share one stimulus stream:
//    dut_a  SKID = 1, CNT_W = 16
//    dut_b  SKID = 0, CNT_W = 16
//    dut_c  SKID = 1, CNT_W = 4  (stall counter saturation)
// Each SKID variant has its own scoreboard queue holding the beats it
// should currently contain; the queue head is the required output.
module tb_pipe_stage_skid;
   localparam int DW = 160;
   localparam int CW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          flush;
   logic          out_ready;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [DW-1:0] a_out_data, b_out_data, c_out_data;
   logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
   logic [1:0]    a_occ, b_occ, c_occ;
   logic [15:0]   a_stall, b_stall;
   logic [3:0]    c_stall;

   int checks = 0;
   int errors = 0;

   logic [DW+CW-1:0] qa[$];
   logic [DW+CW-1:0] qb[$];
   logic [15:0]      sa, sb;
   logic [3:0]       sc;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_cnt(a_stall));

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_ctrl(b_out_ctrl), .occupancy(b_occ), .stall_cnt(b_stall));

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .out_ctrl(c_out_ctrl), .occupancy(c_occ), .stall_cnt(c_stall));

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the scoreboards (called mid-cycle).
   task automatic check_all(input logic ordy);
      int na;
      int nb;
      logic [DW+CW-1:0] h;
      na = qa.size();
      nb = qb.size();
      chk("a_valid", a_out_valid, na > 0);
      chk("a_occ", a_occ, na);
      chk("a_in_ready", a_in_ready, na < 2);
      chk("a_stall", a_stall, sa);
      if (na > 0) begin
         h = qa[0];
         chk("a_data", a_out_data, h[DW-1:0]);
         chk("a_ctrl", a_out_ctrl, h[DW+CW-1:DW]);
      end else begin
         chk("a_ctrl_bubble", a_out_ctrl, 0);
      end
      chk("b_valid", b_out_valid, nb > 0);
      chk("b_occ", b_occ, nb);
      chk("b_in_ready", b_in_ready, (nb == 0) || ordy);
      chk("b_stall", b_stall, sb);
      if (nb > 0) begin
         h = qb[0];
         chk("b_data", b_out_data, h[DW-1:0]);
         chk("b_ctrl", b_out_ctrl, h[DW+CW-1:DW]);
      end else begin
         chk("b_ctrl_bubble", b_out_ctrl, 0);
      end
      chk("c_valid", c_out_valid, na > 0);
      chk("c_occ", c_occ, na);
      chk("c_in_ready", c_in_ready, na < 2);
      chk("c_stall", c_stall, sc);
      if (na > 0) begin
         h = qa[0];
         chk("c_data", c_out_data, h[DW-1:0]);
         chk("c_ctrl", c_out_ctrl, h[DW+CW-1:DW]);
      end else begin
         chk("c_ctrl_bubble", c_out_ctrl, 0);
      end
   endtask

   // One clock cycle: entered and left at posedge + 1.
   task automatic cyc(input logic iv, input logic [31:0] tag, input logic [CW-1:0] ctl,
                      input logic ordy, input logic fl);
      logic [DW+CW-1:0] beat;
      logic a_in, a_out, b_in, b_out;
      in_valid  = iv;
      in_data   = {5{tag}};
      in_ctrl   = ctl;
      out_ready = ordy;
      flush     = fl;
      beat      = {ctl, {5{tag}}};
      #4;
      check_all(ordy);
      a_in  = iv && (qa.size() < 2);
      a_out = (qa.size() > 0) && ordy;
      b_in  = iv && ((qb.size() == 0) || ordy);
      b_out = (qb.size() > 0) && ordy;
      if ((qa.size() > 0) && !ordy) begin
         if (sa != 16'hFFFF) sa++;
         if (sc != 4'hF) sc++;
      end
      if ((qb.size() > 0) && !ordy && (sb != 16'hFFFF)) sb++;
      if (fl) begin
         qa.delete();
         qb.delete();
      end else begin
         if (a_out) void'(qa.pop_front());
         if (a_in) qa.push_back(beat);
         if (b_out) void'(qb.pop_front());
         if (b_in) qb.push_back(beat);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] base;
      logic [CW-1:0] c;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
      sa = '0; sb = '0; sc = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      // Reset state
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_data", a_out_data, 0);
      chk("rst_a_ctrl", a_out_ctrl, 0);
      chk("rst_a_occ", a_occ, 0);
      chk("rst_a_stall", a_stall, 0);
      chk("rst_a_in_ready", a_in_ready, 1);
      chk("rst_b_data", b_out_data, 0);
      rst = 1'b0;

      // Pass-through: 1,2,3,4 back to back
      for (int i = 1; i <= 4; i++) begin
         c = 9'h100 | CW'(i);
         cyc(1'b1, 32'(i), c, 1'b1, 1'b0);
      end
      cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);

      // Skid fill: A, B under stall, C held off, then release
      cyc(1'b1, 32'hAAAA_0001, 9'h0A1, 1'b0, 1'b0);
      cyc(1'b1, 32'hBBBB_0002, 9'h0B2, 1'b0, 1'b0);
      cyc(1'b1, 32'hCCCC_0003, 9'h0C3, 1'b0, 1'b0);
      cyc(1'b1, 32'hCCCC_0003, 9'h0C3, 1'b0, 1'b0);
      cyc(1'b1, 32'hCCCC_0003, 9'h0C3, 1'b1, 1'b0);
      cyc(1'b1, 32'hCCCC_0003, 9'h0C3, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);

      // Stall counter: one beat held for 10, then 10 more cycles
      cyc(1'b1, 32'h5555_0005, 9'h055, 1'b0, 1'b0);
      base = sa;
      for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 9'h000, 1'b0, 1'b0);
      chk("a_stall_plus10", a_stall - base, 16'd10);
      for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 9'h000, 1'b0, 1'b0);
      chk("c_stall_sat", c_stall, 4'hF);

      // Flush while full, with an all-ones control beat offered
      cyc(1'b1, 32'h6666_0006, 9'h066, 1'b0, 1'b0);
      chk("a_full_before_flush", a_occ, 2);
      cyc(1'b1, 32'hDEAD_BEEF, 9'h1FF, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);

      // Toggling out_ready under continuous in_valid
      for (int i = 0; i < 8; i++) begin
         c = 9'h040 | CW'(i);
         cyc(1'b1, 32'h7000_0000 + 32'(i), c, (i % 2) == 0, 1'b0);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);

      // Asynchronous reset between edges while full
      cyc(1'b1, 32'h8888_0008, 9'h088, 1'b0, 1'b0);
      cyc(1'b1, 32'h9999_0009, 9'h099, 1'b0, 1'b0);
      chk("a_full_before_rst", a_occ, 2);
      in_valid = 1'b1; out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_a_valid", a_out_valid, 0);
      chk("arst_a_ctrl", a_out_ctrl, 0);
      chk("arst_a_occ", a_occ, 0);
      chk("arst_a_in_ready", a_in_ready, 1);
      chk("arst_a_stall", a_stall, 0);
      chk("arst_b_valid", b_out_valid, 0);
      chk("arst_b_occ", b_occ, 0);
      qa.delete(); qb.delete();
      sa = '0; sb = '0; sc = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b1, 32'h1234_5678, 9'h123, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 9'h000, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
